bmc_soft_pipe: RTL and testbench

//  Parametrised, pipelined branch-metric unit for the Viterbi decoder. Supports rate-1/N_CODE codes,

---
 rtl/viterbi_pkg.sv | 15 +
 rtl/bmc_sym_dist.sv | 15 +
 rtl/bmc_soft_pipe.sv | 91 +++++++++
 tb/tb_bmc_soft_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared soft-symbol type, branch-metric width helper and per-symbol distance rule
package viterbi_pkg;
  localparam int SOFT_W_MAX = 16;
  typedef logic [SOFT_W_MAX-1:0] soft_t;
  function automatic int bm_width(input int n_code, input int soft_w);
    return soft_w + $clog2(n_code);
  endfunction
  function automatic soft_t bm_dist(input soft_t s, input int soft_w, input logic b, input logic hard, input logic erase);
    soft_t smax;
    logic msb;
    smax = soft_t'((32'd1 << soft_w) - 32'd1);
    msb = |(s & (soft_t'(1) << (soft_w - 1)));
    return erase ? '0 : hard ? soft_t'(msb != b) : b ? smax - s : s;
  endfunction
endpackage

// File: rtl/bmc_sym_dist.sv
// bmc_sym_dist: distance of one soft symbol to expected bits 0 and 1
module bmc_sym_dist
  import viterbi_pkg::*;
#(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] s,
  input  logic              erase,
  input  logic              hard,
  output logic [SOFT_W-1:0] d0,
  output logic [SOFT_W-1:0] d1
);
  assign d0 = SOFT_W'(bm_dist(soft_t'(s), SOFT_W, 1'b0, hard, erase));
  assign d1 = SOFT_W'(bm_dist(soft_t'(s), SOFT_W, 1'b1, hard, erase));
endmodule

// File: rtl/bmc_soft_pipe.sv
// bmc_soft_pipe: two-stage valid/ready branch-metric unit producing all 2^N_CODE metrics per trellis step
module bmc_soft_pipe
  import viterbi_pkg::*;
#(
  parameter int N_CODE = 2,
  parameter int SOFT_W = 3,
  parameter int STEP_W = 16,
  localparam int NH = 2 ** N_CODE,
  localparam int BM_W = bm_width(N_CODE, SOFT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CODE*SOFT_W-1:0] in_soft,
  input  logic [N_CODE-1:0]        in_erase,
  input  logic                     in_hard,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NH*BM_W-1:0]       out_bm,
  output logic                     out_last,
  output logic [STEP_W-1:0]        out_step
);
  logic [SOFT_W-1:0] d0 [N_CODE];
  logic [SOFT_W-1:0] d1 [N_CODE];
  logic [SOFT_W-1:0] s1_d0 [N_CODE];
  logic [SOFT_W-1:0] s1_d1 [N_CODE];
  logic s1_valid, s1_last, s2_valid, s2_last, s2_ready, s1_moves;
  logic [NH*BM_W-1:0] bm_sum, s2_bm;
  logic [STEP_W-1:0] step_cnt;
  assign s2_ready = !s2_valid || out_ready;
  assign s1_moves = s1_valid && s2_ready;
  assign in_ready = !rst && (!s1_valid || s1_moves);
  for (genvar i = 0; i < N_CODE; i++) begin : g_sym
    bmc_sym_dist #(.SOFT_W(SOFT_W)) u_dist (
      .s    (in_soft[i*SOFT_W +: SOFT_W]),
      .erase(in_erase[i]),
      .hard (in_hard),
      .d0   (d0[i]),
      .d1   (d1[i])
    );
  end
  // bit i of hypothesis h selects which registered distance of symbol i is summed
  for (genvar h = 0; h < NH; h++) begin : g_bm
    logic [BM_W-1:0] acc;
    always_comb begin
      acc = '0;
      for (int i = 0; i < N_CODE; i++)
        acc = acc + BM_W'(((h >> i) & 1) != 0 ? s1_d1[i] : s1_d0[i]);
    end
    assign bm_sum[h*BM_W +: BM_W] = acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_d0    <= '{default: '0};
      s1_d1    <= '{default: '0};
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_d0   <= d0;
        s1_d1   <= d1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_bm    <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bm   <= bm_sum;
        s2_last <= s1_last;
      end
    end
  end
  // the counter always holds the index of the beat currently in S2
  always_ff @(posedge clk) begin
    if (rst) step_cnt <= '0;
    else if (s2_valid && out_ready) step_cnt <= s2_last ? '0 : step_cnt + STEP_W'(1);
  end
  assign out_valid = s2_valid;
  assign out_bm    = s2_bm;
  assign out_last  = s2_last;
  assign out_step  = step_cnt;
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb_bmc_soft_pipe: directed self-checking bench for bmc_soft_pipe (N=2,W=3 and N=3,W=4 instances)
module tb_bmc_soft_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0, in_hard = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_last;
  logic [5:0]  in_soft = '0;
  logic [1:0]  in_erase = '0;
  logic [15:0] out_bm, out_step;
  logic        v3 = 1'b0, r3, ov3, ol3;
  logic [11:0] soft3 = '0;
  logic [47:0] bm3;
  logic [15:0] os3;
  int checks = 0;
  int fails = 0;

  bmc_soft_pipe #(.N_CODE(2), .SOFT_W(3), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_soft(in_soft),
    .in_erase(in_erase), .in_hard(in_hard), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_bm(out_bm), .out_last(out_last), .out_step(out_step)
  );
  bmc_soft_pipe #(.N_CODE(3), .SOFT_W(4), .STEP_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_soft(soft3),
    .in_erase(3'b000), .in_hard(1'b0), .in_last(1'b0), .out_valid(ov3),
    .out_ready(1'b1), .out_bm(bm3), .out_last(ol3), .out_step(os3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_bm(input logic [5:0] s, input logic [1:0] e, input logic hd);
    logic [15:0] r;
    int acc, sv, d;
    bit b;
    r = '0;
    for (int h = 0; h < 4; h++) begin
      acc = 0;
      for (int i = 0; i < 2; i++) begin
        sv = int'(s[i*3 +: 3]);
        b = h[i];
        d = e[i] ? 0 : hd ? int'((sv >> 2) != int'(b)) : (b ? 7 - sv : sv);
        acc += d;
      end
      r[h*4 +: 4] = 4'(acc);
    end
    return r;
  endfunction

  task automatic beat_check(input string nm, input logic [5:0] s, input logic [1:0] e,
                            input logic hd, input logic [15:0] exp);
    in_soft = s; in_erase = e; in_hard = hd; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_latency: out_valid=%b after 1 cycle, required 0", nm, out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_bm !== exp) begin
      fails++;
      $display("FAIL %s: out_valid=%b out_bm=%h, required valid=1 bm=%h", nm, out_valid, out_bm, exp);
    end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bm !== 16'h0 || out_last !== 1'b0 || out_step !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_bm=%h out_last=%b out_step=%0d, required 0", in_ready, out_valid, out_bm, out_last, out_step);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_soft_hard;
    beat_check("soft_basic", {3'd7, 3'd0}, 2'b00, 1'b0, {4'd7, 4'd0, 4'd14, 4'd7});
    beat_check("hard_basic", {3'd7, 3'd0}, 2'b00, 1'b1, {4'd1, 4'd0, 4'd2, 4'd1});
  endtask

  task automatic test_back_to_back;
    logic [5:0]  s [4]  = '{{3'd7, 3'd0}, {3'd7, 3'd0}, {3'd2, 3'd5}, {3'd2, 3'd5}};
    logic        hd [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ex [4] = '{{4'd1, 4'd0, 4'd2, 4'd1}, {4'd7, 4'd0, 4'd14, 4'd7},
                            {4'd1, 4'd2, 4'd0, 4'd1}, {4'd7, 4'd10, 4'd4, 4'd7}};
    out_ready = 1'b1; in_erase = 2'b00; in_last = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = j < 4;
      if (j < 4) begin
        in_soft = s[j]; in_hard = hd[j];
      end
      tick;
      if (j >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_bm !== ex[j-1]) begin
          fails++;
          $display("FAIL alt_beat%0d: out_valid=%b out_bm=%h, required valid=1 bm=%h", j-1, out_valid, out_bm, ex[j-1]);
        end
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_erase;
    beat_check("erase_s1", {3'd6, 3'd5}, 2'b10, 1'b0, {4'd2, 4'd5, 4'd2, 4'd5});
    beat_check("erase_s1_alt", {3'd1, 3'd5}, 2'b10, 1'b0, {4'd2, 4'd5, 4'd2, 4'd5});
    beat_check("erase_all", {3'd6, 3'd5}, 2'b11, 1'b0, 16'h0000);
    beat_check("erase_all_hard", {3'd7, 3'd7}, 2'b11, 1'b1, 16'h0000);
  endtask

  task automatic test_backpressure;
    logic [15:0] q [$];
    logic [15:0] bm_prev = '0;
    logic stall_prev = 1'b0;
    int sent = 0, got = 0, low_seen = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = sent < 8;
      in_soft = {3'(sent), 3'(3*sent+1)};
      in_hard = sent[0];
      in_erase = sent == 5 ? 2'b01 : 2'b00;
      in_last = 1'b0;
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_bm !== bm_prev) begin
          fails++;
          $display("FAIL stall_hold: out_valid=%b out_bm=%h, required valid=1 bm=%h", out_valid, out_bm, bm_prev);
        end
      end
      if (in_valid && !in_ready) low_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || out_bm !== q[0]) begin
          fails++;
          $display("FAIL stream_order: out_bm=%h, required %h (queue size %0d)", out_bm, q.size() > 0 ? q[0] : 16'hxxxx, q.size());
        end
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model_bm(in_soft, in_erase, in_hard));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      bm_prev = out_bm;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (sent != 8 || got != 8 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_count: sent=%0d received=%0d left=%0d, required 8/8/0", sent, got, q.size());
    end
    checks++;
    if (low_seen == 0) begin
      fails++;
      $display("FAIL stream_ready_low: in_ready never low while stalled, required at least one cycle");
    end
  endtask

  task automatic test_frame;
    logic [15:0] st [5] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1};
    logic        ls [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    test_reset;
    out_ready = 1'b1; in_erase = 2'b00; in_hard = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = j < 5;
      if (j < 5) begin
        in_soft = 6'(j); in_last = ls[j];
      end
      tick;
      if (j >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_step !== st[j-1] || out_last !== ls[j-1]) begin
          fails++;
          $display("FAIL frame_step%0d: valid=%b step=%0d last=%b, required 1/%0d/%b", j-1, out_valid, out_step, out_last, st[j-1], ls[j-1]);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick;
  endtask

  task automatic test_reset_in_flight;
    beat_check("pre_reset", {3'd7, 3'd0}, 2'b00, 1'b0, {4'd7, 4'd0, 4'd14, 4'd7});
    out_ready = 1'b0; in_valid = 1'b1; in_soft = {3'd3, 3'd4};
    tick;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flight_setup: out_valid=%b, required 1", out_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_step !== 16'd0 || out_bm !== 16'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flight_reset: out_valid=%b out_step=%0d out_bm=%h in_ready=%b, required 0/0/0/1", out_valid, out_step, out_bm, in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flight_flushed: out_valid=%b, required 0", out_valid);
    end
    beat_check("post_reset", {3'd2, 3'd5}, 2'b00, 1'b0, {4'd7, 4'd10, 4'd4, 4'd7});
  endtask

  task automatic test_wide;
    logic [11:0] s [2] = '{12'hFFF, 12'h000};
    logic [47:0] ex [2] = '{{6'd0, 6'd15, 6'd15, 6'd30, 6'd15, 6'd30, 6'd30, 6'd45},
                            {6'd45, 6'd30, 6'd30, 6'd15, 6'd30, 6'd15, 6'd15, 6'd0}};
    for (int j = 0; j < 2; j++) begin
      soft3 = s[j]; v3 = 1'b1;
      tick;
      v3 = 1'b0;
      tick;
      checks++;
      if (ov3 !== 1'b1 || bm3 !== ex[j]) begin
        fails++;
        $display("FAIL wide_bm%0d: out_valid=%b out_bm=%h, required valid=1 bm=%h", j, ov3, bm3, ex[j]);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_soft_hard;
    test_back_to_back;
    test_erase;
    test_backpressure;
    test_frame;
    test_reset_in_flight;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
